// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Both requesters use wb_req_t; rf_wr_t is the regfile write-port payload.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DATA_W     = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic              valid;
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic              ena;
    reg_addr_t         addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector of registers with a mul/div result outstanding.
// Set wins over clear for the same register; x0 is never busy.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  reg_addr_t waw_addr,
  input  reg_addr_t wb_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      waw_busy,
  output logic      wb_busy,
  output logic      clr_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
  assign waw_busy = busy[waw_addr];
  assign wb_busy  = busy[wb_addr];
  assign clr_busy = busy[clr_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and the mul/div
// result channel, with bounded mul/div starvation and a RAW/WAW scoreboard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_hold,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_addr,
  input  logic [XLEN-1:0] md_data,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            raw_stall,
  output logic [4:0]      rf_write_addr,
  output logic [XLEN-1:0] rf_write_data,
  output logic            rf_write_ena,
  output logic            err
);

  localparam int unsigned            CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]       LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             err_next;

  wb_req_t wb_req;
  wb_req_t md_req;
  wb_req_t win;
  rf_wr_t  rf_wr;

  logic md_commit;
  logic iss_accept;
  logic rs1_busy, rs2_busy, waw_busy, wb_busy, md_busy;

  assign wb_req = '{valid: wb_valid, addr: wb_addr, data: DATA_W'(wb_data)};
  assign md_req = '{valid: md_valid, addr: md_addr, data: DATA_W'(md_data)};

  assign wb_hold = (wait_cnt == LIMIT);

  // Same-cycle grant: pipeline wins unless a starvation hold is in force.
  always_comb begin
    win      = md_req;
    md_ready = 1'b1;
    if (!wb_hold && wb_valid) begin
      win      = wb_req;
      md_ready = 1'b0;
    end
  end

  assign rf_wr = '{ena: win.valid && (win.addr != '0), addr: win.addr, data: win.data};

  assign rf_write_ena  = rf_wr.ena;
  assign rf_write_addr = rf_wr.addr;
  assign rf_write_data = XLEN'(rf_wr.data);

  assign md_commit  = md_valid && md_ready;
  assign iss_ready  = !waw_busy;
  assign iss_accept = iss_valid && iss_ready && (iss_rd != '0);
  assign raw_stall  = rs1_busy | rs2_busy;

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_accept),
    .set_addr (iss_rd),
    .clr_en   (md_commit),
    .clr_addr (md_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .waw_addr (iss_rd),
    .wb_addr  (wb_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .waw_busy (waw_busy),
    .wb_busy  (wb_busy),
    .clr_busy (md_busy)
  );

  // Starvation counter saturates at the limit; any accepted result resets it.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (md_commit)
      wait_cnt_next = '0;
    else if (md_valid && (wait_cnt != LIMIT))
      wait_cnt_next = wait_cnt + CNT_W'(1);
  end

  assign err_next = err
                  | (md_commit && (md_addr != '0) && !md_busy)
                  | (wb_valid && wb_hold)
                  | (wb_valid && wb_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      err      <= err_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int unsigned XLEN  = 64;
  localparam int          LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            wb_hold;
  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_addr;
  logic [XLEN-1:0] md_data;
  logic            iss_valid;
  logic            iss_ready;
  logic [4:0]      iss_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            raw_stall;
  logic [4:0]      rf_write_addr;
  logic [XLEN-1:0] rf_write_data;
  logic            rf_write_ena;
  logic            err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .raw_stall(raw_stall),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_ena(rf_write_ena), .err(err)
  );

  always #5 clk = ~clk;

  // Model state: set of outstanding destinations, blocked-cycle count, error flag.
  bit [31:0] mbusy = '0;
  int        mwait = 0;
  bit        merr  = 1'b0;

  logic            exp_hold, exp_md_ready, exp_iss_ready, exp_raw, exp_ena, pipe_wins;
  logic [4:0]      exp_addr;
  logic [XLEN-1:0] exp_data;

  always_comb begin
    exp_hold      = (mwait == LIMIT);
    pipe_wins     = wb_valid && !exp_hold;
    exp_md_ready  = !pipe_wins;
    exp_addr      = pipe_wins ? wb_addr : md_addr;
    exp_data      = pipe_wins ? wb_data : md_data;
    exp_ena       = (pipe_wins || md_valid) && (exp_addr != 5'd0);
    exp_iss_ready = !mbusy[iss_rd];
    exp_raw       = mbusy[rs1_addr] || mbusy[rs2_addr];
  end

  function automatic bit [31:0] next_busy();
    bit [31:0] b = mbusy;
    if (md_valid && exp_md_ready) b[md_addr] = 1'b0;
    if (iss_valid && exp_iss_ready && iss_rd != 5'd0) b[iss_rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic int next_wait();
    if (md_valid && exp_md_ready) return 0;
    if (md_valid) return (mwait + 1 > LIMIT) ? LIMIT : mwait + 1;
    return mwait;
  endfunction

  function automatic bit next_err();
    bit e = merr;
    if (md_valid && exp_md_ready && md_addr != 5'd0 && !mbusy[md_addr]) e = 1'b1;
    if (wb_valid && exp_hold) e = 1'b1;
    if (wb_valid && mbusy[wb_addr]) e = 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mbusy <= '0;
      mwait <= 0;
      merr  <= 1'b0;
    end else begin
      mbusy <= next_busy();
      mwait <= next_wait();
      merr  <= next_err();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_wb_hold",   64'(wb_hold),   64'(exp_hold));
      chk("m_md_ready",  64'(md_ready),  64'(exp_md_ready));
      chk("m_iss_ready", 64'(iss_ready), 64'(exp_iss_ready));
      chk("m_raw_stall", 64'(raw_stall), 64'(exp_raw));
      chk("m_rf_ena",    64'(rf_write_ena), 64'(exp_ena));
      chk("m_err",       64'(err),       64'(merr));
      if (exp_ena) begin
        chk("m_rf_addr", 64'(rf_write_addr), 64'(exp_addr));
        chk("m_rf_data", 64'(rf_write_data), 64'(exp_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  function automatic logic [4:0] pick_busy();
    for (int t = 0; t < 16; t++) begin
      int r = $urandom_range(1, 31);
      if (mbusy[r]) return 5'(r);
    end
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [4:0] pick_free();
    for (int t = 0; t < 16; t++) begin
      int r = $urandom_range(0, 31);
      if (!mbusy[r]) return 5'(r);
    end
    return 5'd0;
  endfunction

  initial begin
    idle();
    rst = 1'b1; iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    chk_en = 1'b1;
    settle();
    chk("rst_ena", 64'(rf_write_ena), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();
    rst = 1'b0; iss_valid = 1'b0; rs1_addr = 5'd5; iss_rd = 5'd5;
    settle();
    chk("rst_busy5", 64'(raw_stall), 64'd0);
    chk("rst_iss_ready", 64'(iss_ready), 64'd1);
    chk("rst_hold", 64'(wb_hold), 64'd0);
    chk("rst_md_ready", 64'(md_ready), 64'd1);

    // Basic issue/commit.
    tick(); idle(); iss_valid = 1'b1; iss_rd = 5'd7;
    tick(); idle(); rs1_addr = 5'd7;
    settle();
    chk("issue_raw", 64'(raw_stall), 64'd1);
    tick(); md_valid = 1'b1; md_addr = 5'd7; md_data = 64'hDEAD;
    settle();
    chk("commit_ena", 64'(rf_write_ena), 64'd1);
    chk("commit_addr", 64'(rf_write_addr), 64'd7);
    chk("commit_data", 64'(rf_write_data), 64'hDEAD);
    chk("commit_raw_same", 64'(raw_stall), 64'd1);
    tick(); md_valid = 1'b0;
    settle();
    chk("commit_raw_next", 64'(raw_stall), 64'd0);

    // Conflict: pipeline first, mul/div next cycle.
    tick(); idle(); iss_valid = 1'b1; iss_rd = 5'd7;
    tick(); idle();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h11;
    md_valid = 1'b1; md_addr = 5'd7; md_data = 64'h77;
    settle();
    chk("conf_addr", 64'(rf_write_addr), 64'd3);
    chk("conf_data", 64'(rf_write_data), 64'h11);
    chk("conf_md_ready", 64'(md_ready), 64'd0);
    tick(); wb_valid = 1'b0;
    settle();
    chk("conf_md_addr", 64'(rf_write_addr), 64'd7);
    chk("conf_md_data", 64'(rf_write_data), 64'h77);
    chk("conf_md_ready2", 64'(md_ready), 64'd1);

    // Starvation with a well-behaved pipeline.
    tick(); idle(); iss_valid = 1'b1; iss_rd = 5'd8;
    tick(); idle();
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 64'h44;
    md_valid = 1'b1; md_addr = 5'd8; md_data = 64'h88;
    for (int k = 0; k < LIMIT; k++) begin
      settle();
      chk("starve_blocked", 64'(md_ready), 64'd0);
      tick();
    end
    wb_valid = 1'b0;
    settle();
    chk("starve_hold", 64'(wb_hold), 64'd1);
    chk("starve_md_ready", 64'(md_ready), 64'd1);
    chk("starve_addr", 64'(rf_write_addr), 64'd8);
    tick(); md_valid = 1'b0; wb_valid = 1'b1;
    settle();
    chk("starve_release", 64'(wb_hold), 64'd0);
    chk("starve_err", 64'(err), 64'd0);

    // x0 issue and commit.
    tick(); idle(); iss_valid = 1'b1; iss_rd = 5'd0;
    settle();
    chk("x0_iss_ready", 64'(iss_ready), 64'd1);
    tick(); idle(); md_valid = 1'b1; md_addr = 5'd0; md_data = 64'h5;
    settle();
    chk("x0_md_ready", 64'(md_ready), 64'd1);
    chk("x0_ena", 64'(rf_write_ena), 64'd0);
    tick(); idle();
    settle();
    chk("x0_err", 64'(err), 64'd0);

    // Commit to a register with nothing outstanding.
    tick(); md_valid = 1'b1; md_addr = 5'd12;
    tick(); idle();
    settle();
    chk("err_set", 64'(err), 64'd1);
    tick();
    settle();
    chk("err_sticky", 64'(err), 64'd1);

    // Same-cycle issue and commit of rd=9: set wins.
    tick(); iss_valid = 1'b1; iss_rd = 5'd9; md_valid = 1'b1; md_addr = 5'd9;
    tick(); idle(); rs1_addr = 5'd9;
    settle();
    chk("setwins_raw", 64'(raw_stall), 64'd1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    settle();
    chk("rst_err_clear", 64'(err), 64'd0);
    chk("rst_busy_clear", 64'(raw_stall), 64'd0);

    // Pipeline ignores hold: write dropped, mul/div wins, error flagged.
    tick(); idle(); iss_valid = 1'b1; iss_rd = 5'd10;
    tick(); idle();
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 64'h44;
    md_valid = 1'b1; md_addr = 5'd10; md_data = 64'hABC;
    repeat (LIMIT) tick();
    settle();
    chk("viol_hold", 64'(wb_hold), 64'd1);
    chk("viol_addr", 64'(rf_write_addr), 64'd10);
    chk("viol_data", 64'(rf_write_data), 64'hABC);
    tick(); idle();
    settle();
    chk("viol_err", 64'(err), 64'd1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst       = ($urandom_range(0, 299) == 0);
      wb_valid  = exp_hold ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 99) < 60);
      wb_addr   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : pick_free();
      wb_data   = {$urandom, $urandom};
      md_valid  = ($urandom_range(0, 1) == 1);
      md_addr   = ($urandom_range(0, 9) < 8) ? pick_busy() : 5'($urandom_range(0, 31));
      md_data   = {$urandom, $urandom};
      iss_valid = ($urandom_range(0, 9) < 4);
      iss_rd    = 5'($urandom_range(0, 15));
      rs1_addr  = 5'($urandom_range(0, 15));
      rs2_addr  = 5'($urandom_range(0, 15));
    end
    tick(); idle(); rst = 1'b0;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
